result_demux: RTL and testbench
===============================

Name: result_demux

Overview:
- Sequential 1-to-2 demultiplexer for 32-bit datapath results; the distributing counterpart of the 2:1 select mux.
- Accepts one stream under valid/ready and routes each word, by a per-word select bit, into one of two registered output ports, each with its own valid/ready.
- Sits between a producer (ALU/load unit) and two consumers (e.g. register-file writeback and a store/forward path).
- Per-output registered stage gives 1-cycle latency and full throughput; per-output wrapping delivery counters support debug.

Parameters:
- WIDTH, 32, data width of input and both outputs.
- CNT_W, 16, width of each delivered-word counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  producer has a word.
- in_ready  output  1  block accepts word this cycle.
- in_sel  input  1  destination (0 -> out0, 1 -> out1); meaningful only with in_valid.
- in_data  input  WIDTH  word to route.
- out0_valid  output  1  out0 register holds a word.
- out0_ready  input  1  consumer 0 takes word.
- out0_data  output  WIDTH  out0 word.
- out1_valid  output  1  out1 register holds a word.
- out1_ready  input  1  consumer 1 takes word.
- out1_data  output  WIDTH  out1 word.
- cnt0  output  CNT_W  words delivered on out0 (out0_valid & out0_ready), wraps.
- cnt1  output  CNT_W  words delivered on out1, wraps.

Behaviour:
- Reset (rst_n low, async): out0_valid=out1_valid=0, out0_data=out1_data=0, cnt0=cnt1=0. Asserting reset mid-transfer discards held words; no partial state survives. Deassertion is synchronous to clk by upstream.
- Per output k, a one-entry register {valid_k, data_k}. free_k = !valid_k | ready_k (empty, or draining this cycle).
- in_ready = in_sel ? free_1 : free_0; combinational from in_sel, out*_valid and out*_ready. in_ready may be high when in_valid is low.
- accept = in_valid & in_ready; drain_k = valid_k & ready_k.
- At posedge: if accept and in_sel==k, then data_k <= in_data, valid_k <= 1 (overrides drain: simultaneous drain+load keeps valid_k=1 with the new word). Else if drain_k, then valid_k <= 0. Otherwise hold.
- Latency: word accepted in cycle N is visible on out_k in cycle N+1. Throughput is 1 word/cycle when the consumer holds ready high.
- Backpressure: a stalled destination blocks only words selected for it (in_ready low); the producer must hold in_valid, in_sel and in_data stable until accepted. Head-of-line: a blocked word for out0 also blocks later words for out1 (in-order acceptance).
- Non-selected output continues to drain independently in the same cycle as an accept to the other output.
- data_k holds its last value after drain (not cleared); consumers must qualify with valid_k.
- cnt_k increments by 1 on each drain_k cycle, wraps from 2^CNT_W-1 to 0; both counters may increment in the same cycle.
- out*_valid/out*_data/cnt* are direct register outputs (no combinational path from inputs).

Test Plan:
- Reset: rst_n=0 asynchronously mid-cycle with out0 holding 0xDEADBEEF -> out0_valid=0, out0_data=0, cnt0=0 immediately, no clock edge needed.
- Routing: send 0x11111111 sel=0, then 0x22222222 sel=1, both ready=1 -> out0 shows 0x11111111 one cycle after accept, out1 shows 0x22222222 the following cycle; cnt0=1, cnt1=1; in_ready stays 1.
- Streaming: 8 back-to-back words sel=0, values 0..7, out0_ready=1 -> in_ready stays 1, out0 emits 0..7 in consecutive cycles, cnt0=8.
- Backpressure: out0_ready=0, load 0xA5A5A5A5 sel=0, then present 0x5A5A5A5A sel=0 -> in_ready=0, out0_data holds 0xA5A5A5A5. Raise out0_ready -> same-cycle accept; next cycle out0_data=0x5A5A5A5A, out0_valid=1.
- Independence: out0 stalled with word held; present sel=1 word 0xCAFEF00D -> accepted at once, appears on out1 next cycle; out0 unchanged.
- Wrap: CNT_W=4, deliver 17 words on out1 -> cnt1=1, cnt0=0.

Source files
------------

// File: rtl/result_demux_if.sv
// Handshake bundle for result_demux: one valid/ready input stream carrying a
// destination select bit, and two registered valid/ready output streams.
//   master : producer/consumer side (drives in_*, out*_ready)
//   slave  : result_demux side (drives in_ready, out*_valid, out*_data)
interface result_demux_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic             in_sel;
  logic [WIDTH-1:0] in_data;
  logic             out0_valid;
  logic             out0_ready;
  logic [WIDTH-1:0] out0_data;
  logic             out1_valid;
  logic             out1_ready;
  logic [WIDTH-1:0] out1_data;

  modport master (
    output in_valid, in_sel, in_data, out0_ready, out1_ready,
    input  in_ready, out0_valid, out0_data, out1_valid, out1_data
  );

  modport slave (
    input  in_valid, in_sel, in_data, out0_ready, out1_ready,
    output in_ready, out0_valid, out0_data, out1_valid, out1_data
  );
endinterface

// File: rtl/result_demux.sv
// Sequential 1-to-2 demultiplexer for datapath results. Each accepted word is
// routed by in_sel into one of two one-entry output registers, giving 1-cycle
// latency and full throughput per output, plus wrapping delivery counters.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : in_valid/in_ready/in_sel/in_data, out{0,1}_valid/ready/data
//   cnt0, cnt1 : words delivered on out0 / out1 (wrap at 2^CNT_W)
module result_demux #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  result_demux_if.slave    bus,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  logic             valid0_q, valid0_d;
  logic             valid1_q, valid1_d;
  logic [WIDTH-1:0] data0_q, data0_d;
  logic [WIDTH-1:0] data1_q, data1_d;
  logic [CNT_W-1:0] cnt0_q, cnt0_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;

  logic free0, free1, in_ready_c, accept, drain0, drain1;

  // Handshake decode and next-state for both output slots
  always_comb begin
    free0      = !valid0_q || bus.out0_ready;
    free1      = !valid1_q || bus.out1_ready;
    in_ready_c = bus.in_sel ? free1 : free0;
    accept     = bus.in_valid && in_ready_c;
    drain0     = valid0_q && bus.out0_ready;
    drain1     = valid1_q && bus.out1_ready;

    valid0_d = valid0_q;
    valid1_d = valid1_q;
    data0_d  = data0_q;
    data1_d  = data1_q;
    cnt0_d   = cnt0_q;
    cnt1_d   = cnt1_q;

    // A load wins over a drain so back-to-back words keep the slot full
    if (accept && !bus.in_sel) begin
      valid0_d = 1'b1;
      data0_d  = bus.in_data;
    end else if (drain0) begin
      valid0_d = 1'b0;
    end

    if (accept && bus.in_sel) begin
      valid1_d = 1'b1;
      data1_d  = bus.in_data;
    end else if (drain1) begin
      valid1_d = 1'b0;
    end

    if (drain0) cnt0_d = cnt0_q + CNT_W'(1);
    if (drain1) cnt1_d = cnt1_q + CNT_W'(1);
  end

  // Output slot and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid0_q <= 1'b0;
      valid1_q <= 1'b0;
      data0_q  <= '0;
      data1_q  <= '0;
      cnt0_q   <= '0;
      cnt1_q   <= '0;
    end else begin
      valid0_q <= valid0_d;
      valid1_q <= valid1_d;
      data0_q  <= data0_d;
      data1_q  <= data1_d;
      cnt0_q   <= cnt0_d;
      cnt1_q   <= cnt1_d;
    end
  end

  assign bus.in_ready   = in_ready_c;
  assign bus.out0_valid = valid0_q;
  assign bus.out0_data  = data0_q;
  assign bus.out1_valid = valid1_q;
  assign bus.out1_data  = data1_q;
  assign cnt0           = cnt0_q;
  assign cnt1           = cnt1_q;

endmodule

// File: tb/tb_result_demux.sv
// Bench for result_demux: directed vector table, hand-written reset/stream/wrap
// sequences, and randomized traffic against a queue-based reference model.
module tb_result_demux;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned CNT_WS = 4;

  logic clk;
  logic rst_n;
  logic [CNT_W-1:0]  cnt0, cnt1;
  logic [CNT_WS-1:0] cnt0_s, cnt1_s;

  result_demux_if #(.WIDTH(WIDTH)) bus ();
  result_demux_if #(.WIDTH(WIDTH)) bus_s ();

  result_demux #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .cnt0(cnt0), .cnt1(cnt1)
  );

  result_demux #(.WIDTH(WIDTH), .CNT_W(CNT_WS)) dut_s (
    .clk(clk), .rst_n(rst_n), .bus(bus_s), .cnt0(cnt0_s), .cnt1(cnt1_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Directed vector: inputs applied for one cycle, outputs expected before the edge
  typedef struct {
    logic        v;
    logic        sel;
    logic [31:0] d;
    logic        r0;
    logic        r1;
    logic        e_rdy;
    logic        e_v0;
    logic [31:0] e_d0;
    logic        e_v1;
    logic [31:0] e_d1;
    logic [15:0] e_c0;
    logic [15:0] e_c1;
  } vec_t;

  vec_t tbl[13];

  // Reference model: each output is a queue of at most one pending word
  logic [31:0] m_q0[$];
  logic [31:0] m_q1[$];
  logic [31:0] m_last0, m_last1;
  int          m_c0, m_c1;

  task automatic model_reset();
    m_q0.delete();
    m_q1.delete();
    m_last0 = '0;
    m_last1 = '0;
    m_c0 = 0;
    m_c1 = 0;
  endtask

  task automatic drive(input logic v, input logic sel, input logic [31:0] d,
                       input logic r0, input logic r1);
    bus.in_valid   = v;
    bus.in_sel     = sel;
    bus.in_data    = d;
    bus.out0_ready = r0;
    bus.out1_ready = r1;
  endtask

  // One model-checked cycle; called shortly after a rising edge
  task automatic mstep(input logic v, input logic sel, input logic [31:0] d,
                       input logic r0, input logic r1, output logic acc);
    logic exp_rdy;
    drive(v, sel, d, r0, r1);
    #1;
    exp_rdy = sel ? (m_q1.size() == 0 || r1) : (m_q0.size() == 0 || r0);
    chk("in_ready",   32'(bus.in_ready),   32'(exp_rdy));
    chk("out0_valid", 32'(bus.out0_valid), 32'(m_q0.size() != 0));
    chk("out1_valid", 32'(bus.out1_valid), 32'(m_q1.size() != 0));
    chk("out0_data",  bus.out0_data, m_last0);
    chk("out1_data",  bus.out1_data, m_last1);
    chk("cnt0", 32'(cnt0), 32'(m_c0));
    chk("cnt1", 32'(cnt1), 32'(m_c1));
    if (m_q0.size() != 0 && r0) begin void'(m_q0.pop_front()); m_c0 = (m_c0 + 1) % 65536; end
    if (m_q1.size() != 0 && r1) begin void'(m_q1.pop_front()); m_c1 = (m_c1 + 1) % 65536; end
    acc = v && exp_rdy;
    if (acc) begin
      if (sel) begin m_q1.push_back(d); m_last1 = d; end
      else     begin m_q0.push_back(d); m_last0 = d; end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    logic        acc;
    logic        pv, psel;
    logic [31:0] pd;
    logic        v, sel, r0, r1;
    logic [31:0] d;

    //            v  sel d             r0 r1 rdy v0 d0            v1 d1            c0 c1
    tbl[0]  = '{1, 0, 32'h11111111, 1, 1, 1, 0, 32'h0,        0, 32'h0,        0, 0};
    tbl[1]  = '{1, 1, 32'h22222222, 1, 1, 1, 1, 32'h11111111, 0, 32'h0,        0, 0};
    tbl[2]  = '{0, 0, 32'h0,        1, 1, 1, 0, 32'h11111111, 1, 32'h22222222, 1, 0};
    tbl[3]  = '{0, 0, 32'h0,        0, 1, 1, 0, 32'h11111111, 0, 32'h22222222, 1, 1};
    tbl[4]  = '{1, 0, 32'hA5A5A5A5, 0, 1, 1, 0, 32'h11111111, 0, 32'h22222222, 1, 1};
    tbl[5]  = '{1, 0, 32'h5A5A5A5A, 0, 1, 0, 1, 32'hA5A5A5A5, 0, 32'h22222222, 1, 1};
    tbl[6]  = '{1, 0, 32'h5A5A5A5A, 0, 1, 0, 1, 32'hA5A5A5A5, 0, 32'h22222222, 1, 1};
    tbl[7]  = '{1, 1, 32'hCAFEF00D, 0, 0, 1, 1, 32'hA5A5A5A5, 0, 32'h22222222, 1, 1};
    tbl[8]  = '{1, 0, 32'h5A5A5A5A, 1, 0, 1, 1, 32'hA5A5A5A5, 1, 32'hCAFEF00D, 1, 1};
    tbl[9]  = '{0, 1, 32'h0,        1, 1, 1, 1, 32'h5A5A5A5A, 1, 32'hCAFEF00D, 2, 1};
    tbl[10] = '{0, 0, 32'h0,        0, 0, 1, 0, 32'h5A5A5A5A, 0, 32'hCAFEF00D, 3, 2};
    tbl[11] = '{1, 1, 32'h0,        0, 0, 1, 0, 32'h5A5A5A5A, 0, 32'hCAFEF00D, 3, 2};
    tbl[12] = '{0, 1, 32'h0,        0, 0, 0, 0, 32'h5A5A5A5A, 1, 32'h0,        3, 2};

    drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
    bus_s.in_valid = 1'b0; bus_s.in_sel = 1'b0; bus_s.in_data = '0;
    bus_s.out0_ready = 1'b0; bus_s.out1_ready = 1'b0;
    do_reset();

    // Reset state
    chk("rst out0_valid", 32'(bus.out0_valid), 32'h0);
    chk("rst out1_valid", 32'(bus.out1_valid), 32'h0);
    chk("rst out0_data", bus.out0_data, 32'h0);
    chk("rst cnt1", 32'(cnt1), 32'h0);

    // Directed table: routing, backpressure, independence, drain+load, head-of-line
    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].v, tbl[i].sel, tbl[i].d, tbl[i].r0, tbl[i].r1);
      #1;
      chk($sformatf("tbl%0d in_ready", i),   32'(bus.in_ready),   32'(tbl[i].e_rdy));
      chk($sformatf("tbl%0d out0_valid", i), 32'(bus.out0_valid), 32'(tbl[i].e_v0));
      chk($sformatf("tbl%0d out0_data", i),  bus.out0_data,       tbl[i].e_d0);
      chk($sformatf("tbl%0d out1_valid", i), 32'(bus.out1_valid), 32'(tbl[i].e_v1));
      chk($sformatf("tbl%0d out1_data", i),  bus.out1_data,       tbl[i].e_d1);
      chk($sformatf("tbl%0d cnt0", i), 32'(cnt0), 32'(tbl[i].e_c0));
      chk($sformatf("tbl%0d cnt1", i), 32'(cnt1), 32'(tbl[i].e_c1));
      @(posedge clk);
      #1;
    end

    // Asynchronous reset mid-cycle with a word held on out0
    drive(1'b1, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
    chk("pre-rst out0_data", bus.out0_data, 32'hDEADBEEF);
    chk("pre-rst out0_valid", 32'(bus.out0_valid), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async rst out0_valid", 32'(bus.out0_valid), 32'h0);
    chk("async rst out0_data", bus.out0_data, 32'h0);
    chk("async rst cnt0", 32'(cnt0), 32'h0);
    chk("async rst out1_valid", 32'(bus.out1_valid), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();

    // Streaming: 8 back-to-back words to out0
    for (int i = 0; i < 8; i++) begin
      mstep(1'b1, 1'b0, 32'(i), 1'b1, 1'b0, acc);
      chk($sformatf("stream accept %0d", i), 32'(acc), 32'h1);
    end
    mstep(1'b0, 1'b0, '0, 1'b1, 1'b0, acc);
    chk("stream cnt0", 32'(cnt0), 32'd8);

    // Randomized traffic; producer holds a word until accepted
    pv = 1'b0; psel = 1'b0; pd = '0;
    for (int i = 0; i < 400; i++) begin
      if (pv) begin
        v = 1'b1; sel = psel; d = pd;
      end else begin
        v = ($urandom_range(3) != 0);
        sel = 1'($urandom_range(1));
        d = $urandom;
      end
      r0 = ($urandom_range(3) != 0);
      r1 = ($urandom_range(2) != 0);
      mstep(v, sel, d, r0, r1, acc);
      pv = v && !acc; psel = sel; pd = d;
    end
    for (int i = 0; i < 3; i++) mstep(1'b0, 1'b0, '0, 1'b1, 1'b1, acc);

    // Counter wrap on the narrow-counter instance: 17 deliveries on out1
    bus_s.out1_ready = 1'b1;
    bus_s.out0_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      bus_s.in_valid = 1'b1;
      bus_s.in_sel   = 1'b1;
      bus_s.in_data  = 32'(i + 100);
      #1;
      chk($sformatf("wrap in_ready %0d", i), 32'(bus_s.in_ready), 32'h1);
      @(posedge clk);
      #1;
    end
    bus_s.in_valid = 1'b0;
    chk("wrap out1_data", bus_s.out1_data, 32'd116);
    @(posedge clk);
    #1;
    chk("wrap cnt1", 32'(cnt1_s), 32'd1);
    chk("wrap cnt0", 32'(cnt0_s), 32'd0);
    chk("wrap out1_valid", 32'(bus_s.out1_valid), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
